character_sprite_drawer: RTL and testbench

- Consumer end of the character-position handshake: takes the per-frame character position from the movement block and renders the 16x16 character sprite to the VGA adapter.
- On each enable it erases the sprite at the previously drawn position (background colour), then draws it at the new position from a synchronous sprite ROM.
- Sits between the movement logic and the VGA adapter plot port.
- Uses the same enable/done handshake as the movement block, so the game controller sequences move then draw.

---
 rtl/character_sprite_drawer.sv | 140 ++++++++++++++
 tb/tb_character_sprite_drawer.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/character_sprite_drawer.sv
// Draws the 16x16 character sprite to the VGA plot port: erases the previous position, then draws the new one from a synchronous ROM.
// Optional: define SPRITE_SKIP_UNCHANGED_EN to skip erase/draw when the position has not changed since the last frame.
`timescale 1ns/1ps
module character_sprite_drawer #(
    parameter int         SPRITE_W    = 16,
    parameter int         SPRITE_H    = 16,
    parameter int         SCREEN_W    = 160,
    parameter int         SCREEN_H    = 120,
    parameter logic [2:0] BG_COLOUR   = 3'b000,
    parameter logic [2:0] TRANSPARENT = 3'b111
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       enable,
    input  logic [7:0] x_position,
    input  logic [7:0] y_position,
    output logic [7:0] rom_address,
    input  logic [2:0] rom_data,
    output logic [7:0] vga_x,
    output logic [6:0] vga_y,
    output logic [2:0] vga_colour,
    output logic       plot,
    output logic       done,
    output logic [2:0] debug_state
);

    // Handshake: enable is held high by the controller until it sees done;
    // done stays high in DONE while enable is high and falls one cycle after enable drops.

    localparam int PIX   = SPRITE_W * SPRITE_H;
    localparam int CNT_W = $clog2(PIX) + 1;
    localparam int COL_W = $clog2(SPRITE_W);
    localparam logic [CNT_W-1:0] LAST_ERASE = CNT_W'(PIX - 1);
    localparam logic [CNT_W-1:0] DRAW_END   = CNT_W'(PIX);

    typedef enum logic [2:0] {IDLE, LATCH, ERASE, PRIME, DRAW, DONE} state_t;

    state_t           state, state_next;
    logic [CNT_W-1:0] cnt;
    logic [7:0]       new_x, new_y, old_x, old_y;
    logic             old_valid;
    logic [8:0]       pipe_x, pipe_y;

    logic [COL_W-1:0]       col;
    logic [CNT_W-COL_W-1:0] row;
    logic [7:0]             base_x, base_y;
    logic [8:0]             sum_x, sum_y;

    assign debug_state = state;

    // Pixel coordinates for the current counter value, relative to the erase or draw origin
    assign col    = cnt[COL_W-1:0];
    assign row    = cnt[CNT_W-1:COL_W];
    assign base_x = (state == ERASE) ? old_x : new_x;
    assign base_y = (state == ERASE) ? old_y : new_y;
    assign sum_x  = {1'b0, base_x} + 9'(col);
    assign sum_y  = {1'b0, base_y} + 9'(row);

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state     <= IDLE;
            cnt       <= '0;
            new_x     <= '0;
            new_y     <= '0;
            old_x     <= '0;
            old_y     <= '0;
            old_valid <= 1'b0;
            pipe_x    <= '0;
            pipe_y    <= '0;
        end else begin
            state <= state_next;
            case (state)
                LATCH: begin
                    new_x <= x_position;
                    new_y <= y_position;
                    cnt   <= '0;
                end
                ERASE: cnt <= (cnt == LAST_ERASE) ? '0 : cnt + 1'b1;
                PRIME, DRAW: begin
                    // ROM data lags the address by a cycle, so the coordinates follow one stage behind
                    cnt    <= cnt + 1'b1;
                    pipe_x <= sum_x;
                    pipe_y <= sum_y;
                    if (state == DRAW && cnt == DRAW_END) begin
                        old_x     <= new_x;
                        old_y     <= new_y;
                        old_valid <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next  = state;
        rom_address = '0;
        vga_x       = '0;
        vga_y       = '0;
        vga_colour  = '0;
        plot        = 1'b0;
        done        = 1'b0;
        case (state)
            IDLE: if (enable) state_next = LATCH;
            LATCH: begin
`ifdef SPRITE_SKIP_UNCHANGED_EN
                if (old_valid && x_position == old_x && y_position == old_y)
                    state_next = DONE;
                else
                    state_next = old_valid ? ERASE : PRIME;
`else
                state_next = old_valid ? ERASE : PRIME;
`endif
            end
            ERASE: begin
                vga_x      = sum_x[7:0];
                vga_y      = sum_y[6:0];
                vga_colour = BG_COLOUR;
                plot       = (sum_x < 9'(SCREEN_W)) && (sum_y < 9'(SCREEN_H));
                if (cnt == LAST_ERASE) state_next = PRIME;
            end
            PRIME: state_next = DRAW;
            DRAW: begin
                rom_address = 8'(cnt);
                vga_x       = pipe_x[7:0];
                vga_y       = pipe_y[6:0];
                vga_colour  = rom_data;
                plot        = (rom_data != TRANSPARENT) &&
                              (pipe_x < 9'(SCREEN_W)) && (pipe_y < 9'(SCREEN_H));
                if (cnt == DRAW_END) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                if (!enable) state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: tb/tb_character_sprite_drawer.sv
// Randomized bench for character_sprite_drawer: a screen-level model lists every expected plot (cycle, x, y, colour) per frame.
`timescale 1ns/1ps
module tb_character_sprite_drawer;

    localparam int SW = 16, SH = 16, SCR_W = 160, SCR_H = 120, NPIX = SW * SH;

    logic       clock = 1'b0, resetn = 1'b0, enable = 1'b0;
    logic [7:0] x_position = '0, y_position = '0;
    logic [7:0] rom_address;
    logic [2:0] rom_data = '0;
    logic [7:0] vga_x;
    logic [6:0] vga_y;
    logic [2:0] vga_colour;
    logic       plot, done;
    logic [2:0] debug_state;

    character_sprite_drawer dut (
        .clock(clock), .resetn(resetn), .enable(enable),
        .x_position(x_position), .y_position(y_position),
        .rom_address(rom_address), .rom_data(rom_data),
        .vga_x(vga_x), .vga_y(vga_y), .vga_colour(vga_colour),
        .plot(plot), .done(done), .debug_state(debug_state)
    );

    // Clock / reset
    always #5 clock = ~clock;

    // Synchronous sprite ROM: data valid one cycle after the address
    logic [2:0] rom_mem [NPIX];
    always @(posedge clock) rom_data <= rom_mem[rom_address];

    // Scoreboard entry: {cycle[27:18], x[17:10], y[9:3], colour[2:0]}, cycle counted from the IDLE cycle sampling enable
    logic [27:0] exp_q[$];
    logic [27:0] obs_q[$];

    int   tests_run = 0, tests_failed = 0;
    int   m_ox = 0, m_oy = 0;
    bit   m_valid = 1'b0;
    int   exp_lat, exp_ab;
    int   lat, addr_bad, hold_bad;
    logic done_after;

    task automatic fill_rom(input bit clear_row0, input bit opaque0);
        for (int i = 0; i < NPIX; i++) rom_mem[i] = 3'($urandom_range(0, 7));
        if (clear_row0) for (int i = 0; i < SW; i++) rom_mem[i] = 3'b111;
        if (opaque0) rom_mem[0] = 3'($urandom_range(0, 6));
    endtask

    // Reference model: what should appear on screen, and when, for a frame at (nx, ny)
    function automatic void build_expected(input int nx, input int ny);
        int ds, x, y;
        exp_q.delete();
`ifdef SPRITE_SKIP_UNCHANGED_EN
        if (m_valid && nx == m_ox && ny == m_oy) begin
            exp_lat = 2;
            exp_ab  = -10000;
            return;
        end
`endif
        ds = m_valid ? 259 : 3;
        if (m_valid) begin
            for (int i = 0; i < NPIX; i++) begin
                x = m_ox + i % SW;
                y = m_oy + i / SW;
                if (x < SCR_W && y < SCR_H) exp_q.push_back({10'(2 + i), 8'(x), 7'(y), 3'b000});
            end
        end
        for (int i = 0; i < NPIX; i++) begin
            x = nx + i % SW;
            y = ny + i / SW;
            if (rom_mem[i] != 3'b111 && x < SCR_W && y < SCR_H)
                exp_q.push_back({10'(ds + i), 8'(x), 7'(y), rom_mem[i]});
        end
        exp_lat = m_valid ? 515 : 259;
        exp_ab  = ds - 1;
    endfunction

    function automatic int first_diff();
        int n;
        n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [27:0] entry_at(input bit from_obs, input int idx);
        if (from_obs) return (idx < obs_q.size()) ? obs_q[idx] : 'x;
        return (idx < exp_q.size()) ? exp_q[idx] : 'x;
    endfunction

    // Driver: one enable/done handshake, recording plots, address order and done behaviour
    task automatic run_frame(input int nx, input int ny, input int hold, input int drop_at);
        obs_q.delete();
        lat = -1; addr_bad = 0; hold_bad = 0;
        @(negedge clock);
        x_position = 8'(nx);
        y_position = 8'(ny);
        enable = 1'b1;
        for (int k = 1; k <= 700 && lat < 0; k++) begin
            @(negedge clock);
            if (plot === 1'b1) obs_q.push_back({10'(k), vga_x, vga_y, vga_colour});
            if (k >= exp_ab && k < exp_ab + NPIX && rom_address !== 8'(k - exp_ab)) addr_bad++;
            if (done === 1'b1) lat = k;
            if (k == drop_at) enable = 1'b0;
            if (k >= 2) begin
                x_position = 8'($urandom);
                y_position = 8'($urandom);
            end
        end
        for (int h = 0; h < hold; h++) begin
            @(negedge clock);
            if (done !== 1'b1 || plot !== 1'b0) hold_bad++;
        end
        enable = 1'b0;
        @(negedge clock);
        done_after = done;
    endtask

    task automatic test_frame(input string name, input int nx, input int ny, input int hold, input int drop_at);
        int idx;
        build_expected(nx, ny);
        run_frame(nx, ny, hold, drop_at);
        idx = first_diff();
        tests_run++;
        if (idx >= 0) begin
            tests_failed++;
            $display("FAIL %s plots: first diff at #%0d got %h want %h (got %0d plots, want %0d)",
                     name, idx, entry_at(1, idx), entry_at(0, idx), obs_q.size(), exp_q.size());
        end
        tests_run++;
        if (lat !== exp_lat) begin
            tests_failed++;
            $display("FAIL %s latency: got %0d want %0d", name, lat, exp_lat);
        end
        tests_run++;
        if (addr_bad !== 0) begin
            tests_failed++;
            $display("FAIL %s rom_address order: %0d wrong addresses, want 0", name, addr_bad);
        end
        tests_run++;
        if (hold_bad !== 0) begin
            tests_failed++;
            $display("FAIL %s done hold: %0d bad cycles, want 0", name, hold_bad);
        end
        tests_run++;
        if (done_after !== 1'b0) begin
            tests_failed++;
            $display("FAIL %s done release: got %b want 0", name, done_after);
        end
        m_ox = nx; m_oy = ny; m_valid = 1'b1;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge clock);
        tests_run++;
        if ({rom_address, vga_x, vga_y, vga_colour, plot, done, debug_state} !== '0) begin
            tests_failed++;
            $display("FAIL reset_held outputs: got %h/%h/%h/%h/%b/%b state %0d want all 0",
                     rom_address, vga_x, vga_y, vga_colour, plot, done, debug_state);
        end
        resetn = 1'b1;
        repeat (2) @(negedge clock);
        tests_run++;
        if ({rom_address, vga_x, vga_y, vga_colour, plot, done, debug_state} !== '0) begin
            tests_failed++;
            $display("FAIL reset_idle outputs: got %h/%h/%h/%h/%b/%b state %0d want all 0",
                     rom_address, vga_x, vga_y, vga_colour, plot, done, debug_state);
        end
        m_valid = 1'b0;
    endtask

    task automatic test_first_frame();
        fill_rom(1'b0, 1'b1);
        test_frame("first", 72, 103, $urandom_range(1, 5), 0);
        tests_run++;
        if (obs_q.size() == 0 || obs_q[0] !== {10'd3, 8'd72, 7'd103, rom_mem[0]}) begin
            tests_failed++;
            $display("FAIL first_pixel: got %h want %h", entry_at(1, 0), {10'd3, 8'd72, 7'd103, rom_mem[0]});
        end
    endtask

    task automatic test_second_frame();
        int n;
        fill_rom(1'b0, 1'b0);
        test_frame("second", 72, 100, $urandom_range(1, 5), 0);
        n = 0;
        foreach (obs_q[i]) if (obs_q[i][27:18] < 10'd258) n++;
        tests_run++;
        if (n !== 256) begin
            tests_failed++;
            $display("FAIL second erase_count: got %0d want 256", n);
        end
    endtask

    task automatic test_edge_clip();
        int n, bad;
        fill_rom(1'b0, 1'b0);
        test_frame("clip", 150, 110, $urandom_range(0, 3), 0);
        n = 0; bad = 0;
        foreach (obs_q[i]) begin
            if (obs_q[i][27:18] >= 10'd259) n++;
            if (obs_q[i][17:10] >= 8'd160 || obs_q[i][9:3] >= 7'd120) bad++;
        end
        tests_run++;
        if (n > 100 || bad !== 0) begin
            tests_failed++;
            $display("FAIL clip bounds: got %0d draw plots and %0d off-screen plots, want <=100 and 0", n, bad);
        end
        fill_rom(1'b0, 1'b0);
        test_frame("bottom_right", 144, 104, $urandom_range(0, 3), 0);
        fill_rom(1'b0, 1'b0);
        test_frame("origin", 0, 0, $urandom_range(0, 3), 0);
    endtask

    task automatic test_transparent_row();
        int n;
        fill_rom(1'b1, 1'b0);
        test_frame("transparent", $urandom_range(0, 144), $urandom_range(0, 104), 1, 0);
        n = 0;
        foreach (obs_q[i]) if (obs_q[i][27:18] > 10'(exp_ab) && obs_q[i][27:18] <= 10'(exp_ab + SW)) n++;
        tests_run++;
        if (n !== 0) begin
            tests_failed++;
            $display("FAIL transparent row0: got %0d plots want 0", n);
        end
    endtask

    task automatic test_enable_drop();
        fill_rom(1'b0, 1'b0);
        test_frame("enable_drop", $urandom_range(0, 170), $urandom_range(0, 127), 0, 5);
    endtask

    task automatic test_reset_mid_erase();
        @(negedge clock);
        x_position = 8'd40;
        y_position = 8'd20;
        enable = 1'b1;
        repeat (100) @(negedge clock);
        resetn = 1'b0;
        #1;
        tests_run++;
        if (plot !== 1'b0 || done !== 1'b0 || debug_state !== 3'd0) begin
            tests_failed++;
            $display("FAIL reset_mid_erase: got plot=%b done=%b state=%0d want 0/0/0", plot, done, debug_state);
        end
        enable = 1'b0;
        @(negedge clock);
        resetn = 1'b1;
        m_valid = 1'b0;
        fill_rom(1'b0, 1'b0);
        test_frame("after_reset", 40, 20, 2, 0);
    endtask

    task automatic test_repeat_position();
        test_frame("repeat", m_ox, m_oy, 2, 0);
    endtask

    task automatic test_random();
        for (int f = 0; f < 4; f++) begin
            fill_rom(1'b0, 1'b0);
            test_frame($sformatf("random%0d", f), $urandom_range(0, 170), $urandom_range(0, 127),
                       $urandom_range(0, 4), 0);
        end
    endtask

    initial begin
        test_reset();
        test_first_frame();
        test_second_frame();
        test_edge_clip();
        test_transparent_row();
        test_enable_drop();
        test_reset_mid_erase();
        test_repeat_position();
        test_random();
        test_repeat_position();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
